// File: rtl/lvds_pkg.sv
// rtl/lvds_pkg.sv - shared state encodings and width defaults for the LVDS capture controller
// Purpose: FSM state type, default sample/word widths and the samples-per-word derivation.
// Ports: none (package).
package lvds_pkg;

    localparam int LVDS_DATA_LEN = 8;
    localparam int LVDS_WORD_LEN = 32;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARMED   = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_FLUSH   = 3'd3,
        ST_DONE    = 3'd4
    } cap_state_e;

    function automatic int lvds_spw(input int data_len, input int word_len);
        return word_len / data_len;
    endfunction

endpackage

// File: rtl/lvds_sample_packer.sv
// rtl/lvds_sample_packer.sv - packs DATA_LEN samples into WORD_LEN words, low slot first
// Purpose: slot index, sample insert, zero-padded partial word, word-complete pulse.
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   clear       drop the partial word and restart at slot 0
//   wr_en, din  write one sample into the current slot
//   word        packed word including the sample being written this cycle
//   word_done   this write fills the last slot; word is complete
//   empty       no sample held in the partial word
module lvds_sample_packer
    import lvds_pkg::*;
#(
    parameter int DATA_LEN = LVDS_DATA_LEN,
    parameter int WORD_LEN = LVDS_WORD_LEN
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clear,
    input  logic                wr_en,
    input  logic [DATA_LEN-1:0] din,
    output logic [WORD_LEN-1:0] word,
    output logic                word_done,
    output logic                empty
);
    localparam int SPW   = lvds_spw(DATA_LEN, WORD_LEN);
    localparam int IDX_W = (SPW > 1) ? $clog2(SPW) : 1;

    logic [IDX_W-1:0]    idx_q;
    logic [WORD_LEN-1:0] word_q;

    // The stored word is cleared after every completed word, so unused
    // upper slots of a partial word already read as zero on flush.
    always_comb begin
        word = word_q;
        for (int s = 0; s < SPW; s++) begin
            if (wr_en && idx_q == IDX_W'(s)) begin
                word[s*DATA_LEN +: DATA_LEN] = din;
            end
        end
    end

    assign word_done = wr_en && (idx_q == IDX_W'(SPW - 1));
    assign empty     = (idx_q == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q  <= '0;
            word_q <= '0;
        end else if (clear || word_done) begin
            idx_q  <= '0;
            word_q <= '0;
        end else if (wr_en) begin
            idx_q  <= idx_q + IDX_W'(1);
            word_q <= word;
        end
    end

endmodule

// File: rtl/lvds_capture_ctrl.sv
// rtl/lvds_capture_ctrl.sv - trigger/capture controller packing post-trigger LVDS samples into words
// Purpose: arm on Arm rising edge, wait for a trigger, capture PostCount samples (0 = continuous),
//   pack them into WORD_LEN words and hand them out through a one-deep valid/ready register.
// Build option: LVDS_EDGE_TRIG_EN selects change-detect triggering instead of level match.
// Ports:
//   Clock, Reset_n         receiver clock, asynchronous active-low reset
//   DataIN, StrobIN        sample and its qualifier
//   Arm                    level; rising edge arms, low aborts
//   TrigMask, TrigValue    trigger compare mask and value (latched on arm)
//   PostCount              samples to capture including the trigger sample (latched on arm)
//   WordOUT, WordValid     packed word, sample 0 in the low bits; held until WordReady
//   WordReady              consumer accept
//   Overflow               sticky, a completed word was dropped; cleared on arm
//   Done                   capture finished and last word accepted
//   State                  FSM state for debug
module lvds_capture_ctrl
    import lvds_pkg::*;
#(
    parameter int DATA_LEN = LVDS_DATA_LEN,
    parameter int WORD_LEN = LVDS_WORD_LEN,
    parameter int CNT_W    = 16
) (
    input  logic                Clock,
    input  logic                Reset_n,
    input  logic [DATA_LEN-1:0] DataIN,
    input  logic                StrobIN,
    input  logic                Arm,
    input  logic [DATA_LEN-1:0] TrigMask,
    input  logic [DATA_LEN-1:0] TrigValue,
    input  logic [CNT_W-1:0]    PostCount,
    output logic [WORD_LEN-1:0] WordOUT,
    output logic                WordValid,
    input  logic                WordReady,
    output logic                Overflow,
    output logic                Done,
    output logic [2:0]          State
);
    cap_state_e          state_q, state_d;
    logic                arm_q;
    logic [DATA_LEN-1:0] mask_q, value_q;
    logic [CNT_W-1:0]    post_q, cnt_q;
    logic                arm_start, abort, pk_wr, flush_load, set_done;
    logic                trig_hit, last_sample, can_load;
    logic [WORD_LEN-1:0] pk_word;
    logic                pk_word_done, pk_empty;

    assign can_load    = !WordValid || WordReady;
    // cnt_q counts samples already captured; this write is number cnt_q+1.
    assign last_sample = (post_q != '0) && (cnt_q + CNT_W'(1) == post_q);
    assign State       = state_q;

`ifdef LVDS_EDGE_TRIG_EN
    logic [DATA_LEN-1:0] prev_q;
    logic                prev_valid_q;

    assign trig_hit = prev_valid_q && (((DataIN ^ prev_q) & mask_q) != '0);

    // Only strobed samples seen while armed form the comparison history.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            prev_q       <= '0;
            prev_valid_q <= 1'b0;
        end else if (arm_start) begin
            prev_valid_q <= 1'b0;
        end else if (state_q == ST_ARMED && StrobIN) begin
            prev_q       <= DataIN;
            prev_valid_q <= 1'b1;
        end
    end
`else
    assign trig_hit = ((DataIN ^ value_q) & mask_q) == '0;
`endif

    always_comb begin
        state_d    = state_q;
        arm_start  = 1'b0;
        abort      = 1'b0;
        pk_wr      = 1'b0;
        flush_load = 1'b0;
        set_done   = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (Arm && !arm_q) begin
                    state_d   = ST_ARMED;
                    arm_start = 1'b1;
                end
            end
            ST_ARMED: begin
                if (!Arm) begin
                    abort = 1'b1;
                end else if (StrobIN && trig_hit) begin
                    pk_wr   = 1'b1;
                    state_d = last_sample ? ST_FLUSH : ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                if (!Arm) begin
                    abort = 1'b1;
                end else if (StrobIN) begin
                    pk_wr = 1'b1;
                    if (last_sample) begin
                        state_d = ST_FLUSH;
                    end
                end
            end
            ST_FLUSH: begin
                // The partial word waits for a free output register rather
                // than being dropped; completion waits for it to drain.
                if (!Arm) begin
                    abort = 1'b1;
                end else if (!pk_empty) begin
                    flush_load = can_load;
                end else if (!WordValid) begin
                    state_d  = ST_DONE;
                    set_done = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (abort) begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q   <= ST_IDLE;
            arm_q     <= 1'b0;
            mask_q    <= '0;
            value_q   <= '0;
            post_q    <= '0;
            cnt_q     <= '0;
            WordOUT   <= '0;
            WordValid <= 1'b0;
            Overflow  <= 1'b0;
            Done      <= 1'b0;
        end else begin
            state_q <= state_d;
            arm_q   <= Arm;
            if (arm_start) begin
                mask_q   <= TrigMask;
                value_q  <= TrigValue;
                post_q   <= PostCount;
                cnt_q    <= '0;
                Overflow <= 1'b0;
                Done     <= 1'b0;
            end else if (pk_wr) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
            if (set_done) begin
                Done <= 1'b1;
            end
            if (pk_word_done || flush_load) begin
                if (can_load) begin
                    WordOUT   <= pk_word;
                    WordValid <= 1'b1;
                end else begin
                    Overflow <= 1'b1;
                end
            end else if (WordValid && WordReady) begin
                WordValid <= 1'b0;
            end
        end
    end

    lvds_sample_packer #(
        .DATA_LEN (DATA_LEN),
        .WORD_LEN (WORD_LEN)
    ) u_packer (
        .clk       (Clock),
        .rst_n     (Reset_n),
        .clear     (arm_start || abort || flush_load),
        .wr_en     (pk_wr),
        .din       (DataIN),
        .word      (pk_word),
        .word_done (pk_word_done),
        .empty     (pk_empty)
    );

endmodule

// File: tb/tb_lvds_capture_ctrl.sv
// tb/tb_lvds_capture_ctrl.sv - scoreboard bench for lvds_capture_ctrl
module tb_lvds_capture_ctrl;

    logic        Clock = 1'b0;
    logic        Reset_n = 1'b0;
    logic [7:0]  DataIN = '0;
    logic        StrobIN = 1'b0;
    logic        Arm = 1'b0;
    logic [7:0]  TrigMask = '0;
    logic [7:0]  TrigValue = '0;
    logic [15:0] PostCount = '0;
    logic [31:0] WordOUT;
    logic        WordValid;
    logic        WordReady = 1'b1;
    logic        Overflow;
    logic        Done;
    logic [2:0]  State;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          rdy_mode = 0;
    logic [31:0] exp_q[$];

    always #5 Clock = ~Clock;

    lvds_capture_ctrl dut (
        .Clock     (Clock),
        .Reset_n   (Reset_n),
        .DataIN    (DataIN),
        .StrobIN   (StrobIN),
        .Arm       (Arm),
        .TrigMask  (TrigMask),
        .TrigValue (TrigValue),
        .PostCount (PostCount),
        .WordOUT   (WordOUT),
        .WordValid (WordValid),
        .WordReady (WordReady),
        .Overflow  (Overflow),
        .Done      (Done),
        .State     (State)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cycle();
        @(posedge Clock);
        #1;
    endtask

    // Reference: find the trigger in the strobed stream, take PostCount samples,
    // chop into 4-sample words; a short tail is emitted only if capture finished.
    function automatic bit model(input logic [7:0] smp[$], input logic [7:0] mask,
                                 input logic [7:0] value, input int post);
        int          start = -1;
        logic [7:0]  cap[$];
        logic [31:0] w;
        for (int i = 0; i < smp.size(); i++) begin
`ifdef LVDS_EDGE_TRIG_EN
            if (i > 0 && ((smp[i] ^ smp[i-1]) & mask) != 8'h00) begin start = i; break; end
`else
            if (((smp[i] ^ value) & mask) == 8'h00) begin start = i; break; end
`endif
        end
        if (start < 0) return 1'b0;
        for (int i = start; i < smp.size() && (post == 0 || cap.size() < post); i++)
            cap.push_back(smp[i]);
        for (int b = 0; b < cap.size(); b += 4) begin
            if (b + 4 > cap.size() && cap.size() != post) break;
            w = '0;
            for (int k = 0; k < 4 && b + k < cap.size(); k++) w[8*k +: 8] = cap[b+k];
            exp_q.push_back(w);
        end
        return (post != 0) && (cap.size() == post);
    endfunction

    // Consumer: mode 0 always ready, 1 random with at most two idle cycles, 2 stalled.
    initial begin
        int lows = 0;
        forever begin
            @(posedge Clock);
            #1;
            case (rdy_mode)
                0: WordReady = 1'b1;
                2: WordReady = 1'b0;
                default: begin
                    WordReady = (lows >= 2) ? 1'b1 : ($urandom_range(1) == 1);
                    lows = WordReady ? 0 : lows + 1;
                end
            endcase
        end
    end

    // Monitor: pops on every accepted word and checks a pending word is held stable.
    logic [31:0] held_word = '0;
    bit          held = 1'b0;
    always @(negedge Clock) begin
        if (!Reset_n) begin
            held = 1'b0;
        end else begin
            if (held) begin
                check("valid_hold", WordValid, 1);
                check("word_hold", WordOUT, held_word);
            end
            if (WordValid && WordReady) begin
                held = 1'b0;
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_word: got %h expected none", WordOUT);
                end else begin
                    check("word", WordOUT, exp_q.pop_front());
                end
            end else begin
                held      = WordValid;
                held_word = WordOUT;
            end
        end
    end

    // Arm cycle carries a strobed sample that would match; it must be ignored.
    task automatic arm_cfg(input logic [7:0] mask, input logic [7:0] value, input int post);
        Arm = 1'b0;
        StrobIN = 1'b0;
        cycle();
        TrigMask  = mask;
        TrigValue = value;
        PostCount = 16'(post);
        Arm = 1'b1;
        StrobIN = 1'b1;
        DataIN = value;
        cycle();
        StrobIN = 1'b0;
        TrigMask  = 8'($urandom);
        TrigValue = 8'($urandom);
        PostCount = 16'($urandom_range(1, 3));
    endtask

    // gap < 0: strict 1/0 strobe toggling; otherwise percent chance of idle cycles.
    task automatic drive(input logic [7:0] smp[$], input int gap);
        foreach (smp[i]) begin
            if (gap < 0) begin
                if (i > 0) begin StrobIN = 1'b0; DataIN = 8'hEE; cycle(); end
            end else begin
                while ($urandom_range(99) < gap) begin
                    StrobIN = 1'b0;
                    DataIN = 8'($urandom);
                    cycle();
                end
            end
            StrobIN = 1'b1;
            DataIN = smp[i];
            cycle();
        end
        StrobIN = 1'b0;
    endtask

    task automatic finish_run(input bit exp_done, input string tag);
        StrobIN = 1'b0;
        if (exp_done) begin
            for (int i = 0; i < 100 && !Done; i++) cycle();
            check({tag, "_done"}, Done, 1);
            check({tag, "_state_done"}, State, 4);
            check({tag, "_drained_at_done"}, exp_q.size(), 0);
        end else begin
            repeat (4) cycle();
            check({tag, "_no_done"}, Done, 0);
            Arm = 1'b0;
            cycle();
            cycle();
            check({tag, "_abort_idle"}, State, 0);
        end
        for (int i = 0; i < 100 && (exp_q.size() != 0 || WordValid); i++) cycle();
        check({tag, "_drain"}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  s[$];
        logic [31:0] w1;
        logic [7:0]  mask, value;
        int          post, n;
        bit          ed;

        repeat (3) @(posedge Clock);
        #1;
        check("rst_word", WordOUT, 0);
        check("rst_valid", WordValid, 0);
        check("rst_ovf", Overflow, 0);
        check("rst_done", Done, 0);
        check("rst_state", State, 0);
        Reset_n = 1'b1;
        cycle();

        s.delete();
        for (int i = 0; i < 16; i++) s.push_back(8'(i));
        arm_cfg(8'h0F, 8'h05, 8);
        exp_q.push_back(32'h08070605);
        exp_q.push_back(32'h0C0B0A09);
        drive(s, 0);
        finish_run(1'b1, "t2");

        s.delete();
        for (int i = 0; i < 8; i++) s.push_back(8'hA0 + 8'(i));
        arm_cfg(8'h00, 8'h5A, 6);
        exp_q.push_back(32'hA3A2A1A0);
        exp_q.push_back(32'h0000A5A4);
        drive(s, 0);
        finish_run(1'b1, "t3");

        rdy_mode = 2;
        cycle();
        cycle();
        s.delete();
        for (int i = 0; i < 12; i++) s.push_back(8'($urandom));
        w1 = {s[3], s[2], s[1], s[0]};
        arm_cfg(8'h00, 8'h00, 12);
        exp_q.push_back(w1);
        drive(s, 0);
        repeat (3) cycle();
        check("t4_valid", WordValid, 1);
        check("t4_word", WordOUT, w1);
        check("t4_ovf", Overflow, 1);
        check("t4_wait_flush", State, 3);
        rdy_mode = 0;
        finish_run(1'b1, "t4");
        check("t4_ovf_sticky", Overflow, 1);

        arm_cfg(8'h00, 8'h00, 8);
        check("t5_ovf_clr", Overflow, 0);
        check("t5_done_clr", Done, 0);
        s.delete();
        s.push_back(8'h11);
        s.push_back(8'h22);
        drive(s, 0);
        check("t5_capture", State, 2);
        Arm = 1'b0;
        cycle();
        check("t5_idle", State, 0);
        repeat (6) begin
            cycle();
            check("t5_no_word", WordValid, 0);
        end

        s.delete();
        for (int i = 0; i < 9; i++) s.push_back(8'($urandom));
        arm_cfg(8'h00, 8'h00, 0);
        ed = model(s, 8'h00, 8'h00, 0);
        drive(s, -1);
        finish_run(ed, "t6");

        rdy_mode = 1;
        for (int it = 0; it < 25; it++) begin
            mask  = 8'($urandom & $urandom & $urandom);
            value = 8'($urandom);
            post  = $urandom_range(0, 13);
            n     = $urandom_range(4, 24);
            s.delete();
            for (int i = 0; i < n; i++) s.push_back(8'($urandom));
            ed = model(s, mask, value, post);
            arm_cfg(mask, value, post);
            drive(s, 30);
            finish_run(ed, "rnd");
            check("rnd_ovf", Overflow, 0);
        end

        rdy_mode = 2;
        cycle();
        cycle();
        s.delete();
        for (int i = 0; i < 6; i++) s.push_back(8'($urandom));
        arm_cfg(8'h00, 8'h00, 0);
        drive(s, 0);
        check("t1_pending", WordValid, 1);
        Reset_n = 1'b0;
        #1;
        check("t1_word", WordOUT, 0);
        check("t1_valid", WordValid, 0);
        check("t1_ovf", Overflow, 0);
        check("t1_done", Done, 0);
        check("t1_state", State, 0);
        exp_q.delete();
        repeat (2) cycle();
        Reset_n = 1'b1;
        cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
